aq_gemac_mdio_master: RTL and testbench
=======================================

// Module: aq_gemac_mdio_master
// PURPOSE
//  Parametrised IEEE 802.3 Clause 22 MDIO management master for the GEMAC
//  register/PHY management path. Serialises one read or write management frame
//  per request with a programmable MDC divider and preamble length, captures
//  read data, and flags an absent PHY. Sits between the host register block and
//  the MDC/MDIO pad tri-state.
// PARAMETERS
//  CLK_DIV       25  CLK cycles per MDC half-period (>=2); MDC period = 2*CLK_DIV
//  PREAMBLE_LEN  32  preamble '1' bits sent before ST (0..32; 0 = suppression)
// PORTS
//  CLK               in   1   system clock
//  RST_N             in   1   asynchronous, active-low reset
//  MIIM_REQUEST      in   1   start frame; sampled only while MIIM_BUSY=0
//  MIIM_WRITE        in   1   1=write, 0=read (latched at accept)
//  MIIM_PHY_ADDRESS  in   5   PHYAD (C45: PRTAD), latched at accept
//  MIIM_REG_ADDRESS  in   5   REGAD (C45: DEVAD), latched at accept
//  MIIM_WDATA        in   16  write data (C45 address frame: register address)
//  MIIM_C45          in   1   C45 frame select; ignored without macro
//  MIIM_OP           in   2   C45 opcode; ignored without macro
//  MIIM_RDATA        out  16  last read data, holds until next read completes
//  MIIM_RVALID       out  1   1-cycle pulse: read complete, MIIM_RDATA valid
//  MIIM_RERR         out  1   sticky-per-frame: TA bit 2 sampled 1 (no PHY)
//  MIIM_BUSY         out  1   frame in progress
//  MDC               out  1   management clock, low when idle
//  MDIO_IN           in   1   MDIO pad input
//  MDIO_OUT          out  1   MDIO pad output value
//  MDIO_OUT_ENABLE   out  1   1 = drive MDIO_OUT onto pad
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, divider 0; reset mid-frame aborts immediately
//   (MDIO_OUT_ENABLE, MDC, MIIM_BUSY drop asynchronously), no RVALID issued.
//  Accept: cycle with MIIM_BUSY=0 && MIIM_REQUEST=1 latches all request inputs;
//   MIIM_BUSY=1 from next cycle. MIIM_REQUEST while busy is ignored (not queued).
//  Divider: counter 0..CLK_DIV-1, runs only while busy; tick each wrap toggles
//   MDC. First half-period of each bit MDC=0, second MDC=1.
//  Drive: MDIO_OUT/ENABLE change on the cycle MDC goes 0 (bit start); MDIO_IN
//   sampled on the CLK edge where MDC goes 0->1 (mid-bit).
//  Frame (N = PREAMBLE_LEN+32 bits, MSB first):
//   PRE(PREAMBLE_LEN x 1) ST(01) OP(write 01/read 10) PHYAD(5) REGAD(5) TA DATA(16)
//  FSM: IDLE->PRE->ST->OP->PHYAD->REGAD->TA->DATA->DONE->IDLE; PRE skipped if
//   PREAMBLE_LEN=0; per-field 5-bit bit counter reloads at each field entry.
//  TA: write drives 1,0. Read: ENABLE=0 for both TA bits and DATA; TA bit 2
//   sampled; if 1 -> MIIM_RERR=1 at DONE (RERR cleared at accept of next frame).
//  DATA: write shifts WDATA[15] first; read shifts MDIO_IN into bit 0.
//  DONE: one CLK cycle: MDC=0, ENABLE=0, MDIO_OUT=0, BUSY=0 next cycle; for read
//   MIIM_RDATA updated and MIIM_RVALID=1 in same cycle. Busy time = N*2*CLK_DIV+1.
//  Back-to-back: new request accepted earliest the cycle after BUSY falls.
// CONFIGURATION
//  AQ_GEMAC_MDIO_C45_EN defined: when MIIM_C45=1 frame uses ST=00,
//   OP=MIIM_OP (00 address, 01 write, 11 read, 10 read-post-inc); OP 00/01 are
//   write-type TA/data, OP 1x read-type. MIIM_C45=0 -> Clause 22 as above.
//  Undefined: MIIM_C45/MIIM_OP unused; every frame is Clause 22.
// TESTING
//  Write PHY=5'h01 REG=5'h00 WDATA=16'h1140, CLK_DIV=4 -> 32x1, 0101 00001
//   00000 10 0001000101000000 on MDIO at MDC rise, ENABLE=1 throughout, BUSY=513 cyc.
//  Read PHY=5'h1F REG=5'h02, PHY model returns TA=0 + 16'hA5C3 -> ENABLE=0 from TA,
//   RDATA=16'hA5C3, RVALID 1 cycle, RERR=0.
//  Read with MDIO_IN tied 1 -> RERR=1, RDATA=16'hFFFF, RVALID pulses.
//  Second REQUEST 10 cycles after accept -> ignored; only one frame on MDIO.
//  RST_N low at DATA bit 7 -> MDC/ENABLE/BUSY 0 immediately; next request frames cleanly.
//  PREAMBLE_LEN=0, CLK_DIV=2 -> frame starts with 01, BUSY=129 cycles; with
//   AQ_GEMAC_MDIO_C45_EN, C45=1 OP=00 -> ST/OP bits 00 00, data=WDATA.

Source files
------------

// File: rtl/aq_gemac_mdio_master.sv
// aq_gemac_mdio_master
// IEEE 802.3 Clause 22 MDIO management master. It sends one read or write
// frame per accepted request and returns read data. A TA bit of 1 means that
// no PHY answered.
// Defining AQ_GEMAC_MDIO_C45_EN adds Clause 45 framing (ST=00, OP from
// MIIM_OP) for requests that set MIIM_C45=1.
module aq_gemac_mdio_master #(
  parameter int CLK_DIV      = 25,  // CLK cycles per MDC half-period, >= 2
  parameter int PREAMBLE_LEN = 32   // preamble ones, 0..32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MIIM_REQUEST,
  input  logic        MIIM_WRITE,
  input  logic [4:0]  MIIM_PHY_ADDRESS,
  input  logic [4:0]  MIIM_REG_ADDRESS,
  input  logic [15:0] MIIM_WDATA,
  input  logic        MIIM_C45,
  input  logic [1:0]  MIIM_OP,
  output logic [15:0] MIIM_RDATA,
  output logic        MIIM_RVALID,
  output logic        MIIM_RERR,
  output logic        MIIM_BUSY,
  output logic        MDC,
  input  logic        MDIO_IN,
  output logic        MDIO_OUT,
  output logic        MDIO_OUT_ENABLE
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic             PRE_EN   = (PREAMBLE_LEN > 0);
  localparam logic [4:0]       PRE_LAST = PRE_EN ? 5'(PREAMBLE_LEN - 1) : 5'd0;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_PRE  = 4'd1;
  localparam logic [3:0] S_ST   = 4'd2;
  localparam logic [3:0] S_OP   = 4'd3;
  localparam logic [3:0] S_PHY  = 4'd4;
  localparam logic [3:0] S_REG  = 4'd5;
  localparam logic [3:0] S_TA   = 4'd6;
  localparam logic [3:0] S_DATA = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  logic [3:0]       state, adv_state;
  logic [4:0]       bit_cnt, adv_cnt;   // bits left in the field, minus one
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       phy_q, reg_q;
  logic [15:0]      wdata_q, rx_shift;
  logic [1:0]       st_q, op_q;
  logic             rd_q, ta_err;
  logic             tick, mdc_rise, mdc_fall, tx_out, tx_oe;

`ifndef AQ_GEMAC_MDIO_C45_EN
  logic unused_c45;
  assign unused_c45 = ^{MIIM_C45, MIIM_OP};
`endif

  assign tick     = MIIM_BUSY && (div_cnt == DIV_LAST);
  assign mdc_rise = tick && !MDC;
  assign mdc_fall = tick && MDC;

  // Frame position after the current bit: next bit of this field, or the next field.
  always_comb begin
    // NOTE: default every output first so no path leaves one unassigned (no latch).
    adv_state = state;
    adv_cnt   = bit_cnt - 5'd1;
    if (bit_cnt == 5'd0) begin
      case (state)
        S_PRE:   begin adv_state = S_ST;   adv_cnt = 5'd1;  end
        S_ST:    begin adv_state = S_OP;   adv_cnt = 5'd1;  end
        S_OP:    begin adv_state = S_PHY;  adv_cnt = 5'd4;  end
        S_PHY:   begin adv_state = S_REG;  adv_cnt = 5'd4;  end
        S_REG:   begin adv_state = S_TA;   adv_cnt = 5'd1;  end
        S_TA:    begin adv_state = S_DATA; adv_cnt = 5'd15; end
        S_DATA:  begin adv_state = S_DONE; adv_cnt = 5'd0;  end
        default: begin adv_state = S_IDLE; adv_cnt = 5'd0;  end
      endcase
    end
  end

  // Pad value and enable for the bit at the position computed above.
  always_comb begin
    tx_oe  = 1'b1;
    tx_out = 1'b0;
    case (adv_state)
      S_PRE:  tx_out = 1'b1;
      S_ST:   tx_out = st_q[adv_cnt[0]];
      S_OP:   tx_out = op_q[adv_cnt[0]];
      S_PHY:  tx_out = phy_q[adv_cnt[2:0]];
      S_REG:  tx_out = reg_q[adv_cnt[2:0]];
      S_TA:   if (rd_q) tx_oe = 1'b0; else tx_out = adv_cnt[0];  // write TA = 1,0
      S_DATA: if (rd_q) tx_oe = 1'b0; else tx_out = wdata_q[adv_cnt[3:0]];
      default: tx_oe = 1'b0;
    endcase
  end

  // Request accept, MDC divider, bit sequencing and read capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= S_IDLE;
      bit_cnt         <= 5'd0;
      div_cnt         <= '0;
      phy_q           <= 5'd0;
      reg_q           <= 5'd0;
      wdata_q         <= 16'd0;
      st_q            <= 2'b00;
      op_q            <= 2'b00;
      rd_q            <= 1'b0;
      ta_err          <= 1'b0;
      rx_shift        <= 16'd0;
      MIIM_RDATA      <= 16'd0;
      MIIM_RVALID     <= 1'b0;
      MIIM_RERR       <= 1'b0;
      MIIM_BUSY       <= 1'b0;
      MDC             <= 1'b0;
      MDIO_OUT        <= 1'b0;
      MDIO_OUT_ENABLE <= 1'b0;
    end else begin
      // NOTE: non-blocking updates, so every register here sees the values from before the edge.
      MIIM_RVALID <= 1'b0;
      if (!MIIM_BUSY) begin
        div_cnt <= '0;
        if (MIIM_REQUEST) begin
          phy_q     <= MIIM_PHY_ADDRESS;
          reg_q     <= MIIM_REG_ADDRESS;
          wdata_q   <= MIIM_WDATA;
          st_q      <= 2'b01;
          op_q      <= MIIM_WRITE ? 2'b01 : 2'b10;
          rd_q      <= !MIIM_WRITE;
`ifdef AQ_GEMAC_MDIO_C45_EN
          if (MIIM_C45) begin
            st_q <= 2'b00;
            op_q <= MIIM_OP;
            rd_q <= MIIM_OP[1];
          end
`endif
          MIIM_BUSY       <= 1'b1;
          MIIM_RERR       <= 1'b0;
          ta_err          <= 1'b0;
          MDC             <= 1'b0;
          state           <= PRE_EN ? S_PRE : S_ST;
          bit_cnt         <= PRE_EN ? PRE_LAST : 5'd1;
          // The first bit is a preamble 1, or the leading 0 of ST.
          MDIO_OUT        <= PRE_EN;
          MDIO_OUT_ENABLE <= 1'b1;
        end
      end else if (state == S_DONE) begin
        MIIM_BUSY <= 1'b0;
        state     <= S_IDLE;
        div_cnt   <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (mdc_rise) begin
          MDC <= 1'b1;
          if (rd_q && state == S_TA && bit_cnt == 5'd0) ta_err <= MDIO_IN;
          if (rd_q && state == S_DATA) rx_shift <= {rx_shift[14:0], MDIO_IN};
        end
        if (mdc_fall) begin
          MDC             <= 1'b0;
          state           <= adv_state;
          bit_cnt         <= adv_cnt;
          MDIO_OUT        <= tx_out;
          MDIO_OUT_ENABLE <= tx_oe;
          if (adv_state == S_DONE) begin
            MIIM_RERR <= rd_q && ta_err;
            if (rd_q) begin
              MIIM_RDATA  <= rx_shift;
              MIIM_RVALID <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aq_gemac_mdio_master.sv
// tb_aq_gemac_mdio_master
// Runs two masters side by side from one request bus. The first uses CLK_DIV=4
// and a 32-bit preamble. The second uses CLK_DIV=2 and no preamble. A per-cycle
// model checks both against the expected frame and timing. Each master also
// has its own PHY responder.
module tb_aq_gemac_mdio_master;

  localparam int D0 = 4, P0 = 32, D1 = 2, P1 = 0;

  int div_p [2] = '{D0, D1};
  int pre_p [2] = '{P0, P1};

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req = 1'b0, wr = 1'b0, c45 = 1'b0;
  logic [4:0]  phy_ad = 5'd0, reg_ad = 5'd0;
  logic [15:0] wdata = 16'd0;
  logic [1:0]  op = 2'd0;
  logic        mdio_in [2] = '{1'b0, 1'b0};
  logic [15:0] rdata [2];
  logic        rvalid [2], rerr [2], busy [2], mdc [2], mdo [2], mdoe [2];

  // PHY response for the next accepted read
  bit          phy_ta2 = 1'b0, tie1 = 1'b0;
  logic [15:0] phy_data = 16'd0;

  always #5 CLK = ~CLK;

  aq_gemac_mdio_master #(.CLK_DIV(D0), .PREAMBLE_LEN(P0)) dut (
    .CLK(CLK), .RST_N(RST_N), .MIIM_REQUEST(req), .MIIM_WRITE(wr),
    .MIIM_PHY_ADDRESS(phy_ad), .MIIM_REG_ADDRESS(reg_ad), .MIIM_WDATA(wdata),
    .MIIM_C45(c45), .MIIM_OP(op), .MIIM_RDATA(rdata[0]), .MIIM_RVALID(rvalid[0]),
    .MIIM_RERR(rerr[0]), .MIIM_BUSY(busy[0]), .MDC(mdc[0]), .MDIO_IN(mdio_in[0]),
    .MDIO_OUT(mdo[0]), .MDIO_OUT_ENABLE(mdoe[0]));

  aq_gemac_mdio_master #(.CLK_DIV(D1), .PREAMBLE_LEN(P1)) dut_np (
    .CLK(CLK), .RST_N(RST_N), .MIIM_REQUEST(req), .MIIM_WRITE(wr),
    .MIIM_PHY_ADDRESS(phy_ad), .MIIM_REG_ADDRESS(reg_ad), .MIIM_WDATA(wdata),
    .MIIM_C45(c45), .MIIM_OP(op), .MIIM_RDATA(rdata[1]), .MIIM_RVALID(rvalid[1]),
    .MIIM_RERR(rerr[1]), .MIIM_BUSY(busy[1]), .MDC(mdc[1]), .MDIO_IN(mdio_in[1]),
    .MDIO_OUT(mdo[1]), .MDIO_OUT_ENABLE(mdoe[1]));

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_active [2];
  int          m_k [2];          // cycles since accept, 1-based
  int          m_n [2];
  bit          m_read [2], m_tie [2], m_exp_err [2], m_rerr [2];
  logic [15:0] m_exp_rd [2], m_rdata [2];
  bit          f_out [2][64], f_oe [2][64], resp [2][64];

  function automatic int total(input int i);
    return (pre_p[i] + 32) * 2 * div_p[i] + 1;
  endfunction

  task automatic push(input int i, input bit v, input bit oe, input bit r);
    f_out[i][m_n[i]] = v;
    f_oe[i][m_n[i]]  = oe;
    resp[i][m_n[i]]  = r;
    m_n[i]++;
  endtask

  task automatic build_frame(input int i);
    logic [1:0] st, opv;
    bit rd;
    st  = 2'b01;
    opv = wr ? 2'b01 : 2'b10;
    rd  = !wr;
`ifdef AQ_GEMAC_MDIO_C45_EN
    if (c45) begin st = 2'b00; opv = op; rd = op[1]; end
`endif
    m_n[i]      = 0;
    m_read[i]   = rd;
    m_tie[i]    = tie1;
    m_exp_rd[i] = tie1 ? 16'hFFFF : phy_data;
    m_exp_err[i] = tie1 ? 1'b1 : phy_ta2;
    for (int b = 0; b < pre_p[i]; b++) push(i, 1'b1, 1'b1, 1'($urandom));
    for (int b = 1; b >= 0; b--) push(i, st[b], 1'b1, 1'($urandom));
    for (int b = 1; b >= 0; b--) push(i, opv[b], 1'b1, 1'($urandom));
    for (int b = 4; b >= 0; b--) push(i, phy_ad[b], 1'b1, 1'($urandom));
    for (int b = 4; b >= 0; b--) push(i, reg_ad[b], 1'b1, 1'($urandom));
    if (rd) begin
      push(i, 1'b0, 1'b0, 1'($urandom));
      push(i, 1'b0, 1'b0, phy_ta2);
      for (int b = 15; b >= 0; b--) push(i, 1'b0, 1'b0, phy_data[b]);
    end else begin
      push(i, 1'b1, 1'b1, 1'($urandom));
      push(i, 1'b0, 1'b1, 1'($urandom));
      for (int b = 15; b >= 0; b--) push(i, wdata[b], 1'b1, 1'($urandom));
    end
  endtask

  // Model clock: accept when idle and requested, and count the frame cycles.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 1'b0; m_k[i] = 0; m_rerr[i] = 1'b0; m_rdata[i] = 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_active[i]) begin
          if (m_k[i] == total(i)) m_active[i] = 1'b0;
          else begin
            m_k[i]++;
            if (m_k[i] == total(i) && m_read[i]) begin
              m_rdata[i] = m_exp_rd[i];
              m_rerr[i]  = m_exp_err[i];
            end
          end
        end else if (req) begin
          build_frame(i);
          m_active[i] = 1'b1;
          m_k[i]      = 1;
          m_rerr[i]   = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare, PHY responder and MDC-rise capture.
  logic [63:0] cap [2];
  int          bcnt [2], rvcnt [2];
  logic        prev_mdc [2] = '{1'b0, 1'b0};

  always @(negedge CLK) begin
    int k, b, ph;
    bit e_busy, e_mdc, e_oe, e_out, e_rv, chk_out, in_bit;
    for (int i = 0; i < 2; i++) begin
      e_busy = 0; e_mdc = 0; e_oe = 0; e_out = 0; e_rv = 0; chk_out = 1; in_bit = 0;
      k = m_k[i]; b = 0;
      if (m_active[i]) begin
        e_busy = 1;
        if (k < total(i)) begin
          b  = (k - 1) / (2 * div_p[i]);
          ph = (k - 1) % (2 * div_p[i]);
          e_mdc   = (ph >= div_p[i]);
          e_oe    = f_oe[i][b];
          e_out   = f_out[i][b];
          chk_out = e_oe;
          in_bit  = 1;
        end else e_rv = m_read[i];
      end
      check($sformatf("busy%0d", i), busy[i], e_busy);
      check($sformatf("mdc%0d", i), mdc[i], e_mdc);
      check($sformatf("oe%0d", i), mdoe[i], e_oe);
      if (chk_out) check($sformatf("mdio_out%0d", i), mdo[i], e_out);
      check($sformatf("rvalid%0d", i), rvalid[i], e_rv);
      check($sformatf("rerr%0d", i), rerr[i], m_rerr[i]);
      check($sformatf("rdata%0d", i), rdata[i], m_rdata[i]);

      mdio_in[i] = in_bit ? (m_tie[i] ? 1'b1 : resp[i][b]) : 1'($urandom);

      if (m_active[i] && m_k[i] == 1) begin cap[i] = '0; bcnt[i] = 0; rvcnt[i] = 0; end
      if (busy[i]) bcnt[i]++;
      if (rvalid[i]) rvcnt[i]++;
      if (mdc[i] && !prev_mdc[i]) cap[i] = {cap[i][62:0], mdo[i]};
      prev_mdc[i] = mdc[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while ((m_active[0] || m_active[1]) && n < 3000) begin @(negedge CLK); n++; end
    check("idle_reached", {m_active[0], m_active[1]}, 2'b00);
  endtask

  // Raise the request. With b2b, it goes up before the slow master finishes.
  task automatic start(input bit b2b);
    int n = 0;
    if (b2b) while (m_active[0] && m_k[0] < total(0) - 3 && n < 3000) begin @(negedge CLK); n++; end
    else wait_idle();
    req = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!(m_active[0] && m_k[0] == 1) && n < 3000);
    req = 1'b0;
    check("accept_busy0", busy[0], 1'b1);
  endtask

  task automatic set_req(input bit w, input logic [4:0] p, input logic [4:0] r,
                         input logic [15:0] d, input bit cc, input logic [1:0] o);
    wr = w; phy_ad = p; reg_ad = r; wdata = d; c45 = cc; op = o;
  endtask

  initial begin
    logic [31:0] v;
    int n;
    repeat (3) @(negedge CLK);
    check("reset_rdata0", rdata[0], 16'h0000);
    check("reset_busy0", busy[0], 1'b0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Write PHY=01 REG=00 WDATA=1140
    set_req(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 2'b00);
    tie1 = 0; phy_ta2 = 0; phy_data = 16'h0;
    start(1'b0);
    wait_idle();
    v = '0;
    for (int b = 0; b < 32; b++) v = {v[30:0], f_out[0][32 + b]};
    check("model_frame_wr", v, 32'h5082_1140);
    v = '0;
    for (int b = 0; b < 32; b++) v = {v[30:0], f_out[0][b]};
    check("model_pre", v, 32'hFFFF_FFFF);
    check("wr_mdio0", cap[0][31:0], 32'h5082_1140);
    check("wr_pre0", cap[0][63:32], 32'hFFFF_FFFF);
    check("wr_mdio1", cap[1][31:0], 32'h5082_1140);
    check("wr_busy0", bcnt[0], 513);
    check("wr_busy1", bcnt[1], 129);

    // Read PHY=1F REG=02, the PHY answers A5C3
    set_req(1'b0, 5'h1F, 5'h02, 16'h0, 1'b0, 2'b00);
    phy_ta2 = 0; phy_data = 16'hA5C3;
    start(1'b0);
    wait_idle();
    check("rd_data0", rdata[0], 16'hA5C3);
    check("rd_data1", rdata[1], 16'hA5C3);
    check("rd_rerr0", rerr[0], 1'b0);
    check("rd_rvcnt0", rvcnt[0], 1);
    check("rd_rvcnt1", rvcnt[1], 1);

    // Read with MDIO_IN tied to 1: no PHY present
    set_req(1'b0, 5'h03, 5'h11, 16'h0, 1'b0, 2'b00);
    tie1 = 1;
    start(1'b0);
    tie1 = 0;
    wait_idle();
    check("nophy_rerr0", rerr[0], 1'b1);
    check("nophy_rerr1", rerr[1], 1'b1);
    check("nophy_data0", rdata[0], 16'hFFFF);
    check("nophy_rvcnt0", rvcnt[0], 1);

    // A second request 10 cycles after accept is ignored
    set_req(1'b1, 5'h0A, 5'h05, 16'hBEEF, 1'b0, 2'b00);
    start(1'b0);
    repeat (9) @(negedge CLK);
    req = 1'b1;
    @(negedge CLK);
    req = 1'b0;
    wait_idle();
    check("ignore_busy0", bcnt[0], 513);
    check("ignore_busy1", bcnt[1], 129);
    check("ignore_mdio0", cap[0][15:0], 16'hBEEF);

    // Reset asserted while MDC is high during a DATA bit (frame bit 55)
    set_req(1'b1, 5'h07, 5'h09, 16'h5A5A, 1'b0, 2'b00);
    start(1'b0);
    n = 0;
    while (m_k[0] != 55 * 2 * D0 + 6 && n < 3000) begin @(negedge CLK); n++; end
    #2 RST_N = 1'b0;
    #1;
    check("rst_mdc0", mdc[0], 1'b0);
    check("rst_oe0", mdoe[0], 1'b0);
    check("rst_busy0", busy[0], 1'b0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    set_req(1'b1, 5'h12, 5'h1C, 16'hC3A5, 1'b0, 2'b00);
    start(1'b0);
    wait_idle();
    check("post_rst_mdio0", cap[0][15:0], 16'hC3A5);
    check("post_rst_busy0", bcnt[0], 513);

`ifdef AQ_GEMAC_MDIO_C45_EN
    // Clause 45 address frame: ST=00, OP=00, data is WDATA
    set_req(1'b1, 5'h02, 5'h01, 16'h1234, 1'b1, 2'b00);
    start(1'b0);
    wait_idle();
    check("c45_stop1", cap[1][31:28], 4'b0000);
    check("c45_data1", cap[1][15:0], 16'h1234);
`endif

    // Randomised traffic, some of it back to back
    for (int t = 0; t < 24; t++) begin
      bit b2b;
      b2b = ($urandom_range(0, 2) == 0);
      set_req(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              1'($urandom), 2'($urandom));
      tie1 = ($urandom_range(0, 3) == 0);
      phy_ta2 = 1'b0;
      phy_data = 16'($urandom);
      start(b2b);
      tie1 = 1'b0;
    end
    wait_idle();
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
